// File: rtl/chu_btn_event_core.sv
// chu_btn_event_core: FPro MMIO slot that debounces the five board pushbuttons,
// turns every debounced press (and optionally release) into a timestamped event
// and queues the events in a small FIFO that the processor drains over the slot bus.
module chu_btn_event_core #(
  parameter int DB_CYCLES  = 2_000_000,
  parameter int TICK_DIV   = 100_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [4:0]  btn
);

  localparam int NBTN = 5;
  localparam int DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PSW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  DEPTH   = CW'(FIFO_DEPTH);

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_HEAD   = 5'd1;
  localparam logic [4:0] ADDR_POP    = 5'd2;
  localparam logic [4:0] ADDR_CTRL   = 5'd3;
  localparam logic [4:0] ADDR_LEVELS = 5'd4;

  // The read strobe and the upper write-data bits carry no meaning for this slot.
  logic unused_bits;
  assign unused_bits = &{1'b0, read, wr_data[31:3]};

  // ---------------------------------------------------------------------------
  // Input synchronisation and debounce
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0]           btn_meta;
  logic [NBTN-1:0]           btn_sync;
  logic [NBTN-1:0]           stable;
  logic [NBTN-1:0]           armed;
  logic [NBTN-1:0][DBW-1:0]  db_cnt;
  logic [NBTN-1:0]           db_fire;
  logic [NBTN-1:0]           raise;
  logic                      rel_en;

  // Two-flop synchroniser, left unreset so it keeps tracking the pins during reset.
  always_ff @(posedge clk) begin
    btn_meta <= btn;
    btn_sync <= btn_meta;
  end

  // A button's debounced level flips once its synced value has differed for DB_CYCLES cycles.
  always_comb begin
    db_fire = '0;
    for (int i = 0; i < NBTN; i++) begin
      db_fire[i] = (btn_sync[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // Events are only reported from buttons seen released since reset, and releases only when enabled.
  assign raise = db_fire & armed & (btn_sync | {NBTN{rel_en}});

  // Per-button debounce counters, stable levels and the "seen released since reset" flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      armed  <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (btn_sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_fire[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= btn_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
        if (!btn_sync[i] && !stable[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------------
  logic [PSW-1:0] presc;
  logic [15:0]    tick_cnt;

  // Prescaler divides clk down to the timestamp tick; the 16-bit tick counter wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      tick_cnt <= '0;
    end else if (presc == PS_LAST) begin
      presc    <= '0;
      tick_cnt <= tick_cnt + 16'd1;
    end else begin
      presc <= presc + PSW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic pop_req;
  logic ctrl_wr;
  logic flush;
  logic ovf_clr;

  assign wr_en   = cs & write;
  assign pop_req = wr_en && (addr == ADDR_POP);
  assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
  assign flush   = ctrl_wr && wr_data[2];
  assign ovf_clr = ctrl_wr && wr_data[1];

  // ---------------------------------------------------------------------------
  // Pending events and push arbiter
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] pending;
  logic [NBTN-1:0] pend_type;
  logic            push_req;
  logic [2:0]      push_idx;
  logic            push_type;
  logic [31:0]     event_word;

  // Lowest-numbered pending button wins the single push slot of this cycle.
  always_comb begin
    push_req  = 1'b0;
    push_idx  = 3'd0;
    push_type = 1'b0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_req  = 1'b1;
        push_idx  = 3'(i);
        push_type = pend_type[i];
      end
    end
  end

  assign event_word = {tick_cnt, 12'd0, push_type, push_idx};

  // A pending bit drops when its event is offered to the FIFO, whether or not it fits.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pending   <= '0;
      pend_type <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (push_req && (push_idx == 3'(i))) begin
          pending[i] <= 1'b0;
        end
        if (raise[i]) begin
          pending[i]   <= 1'b1;
          pend_type[i] <= btn_sync[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop_ok;
  logic          push_ok;
  logic          push_drop;
  logic          overflow;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH);
  assign pop_ok     = pop_req && !fifo_empty && !flush;
  assign push_ok    = push_req && !flush && (!fifo_full || pop_ok);
  assign push_drop  = push_req && !flush && fifo_full && !pop_ok;

  // Event storage; stale contents are never visible because the head read is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= event_word;
    end
  end

  // Pointers and occupancy; a flush empties the queue and overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Control register: stored release enable and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rel_en <= wr_data[0];
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [3:0] status_cnt;
  assign status_cnt = 4'(fifo_count);

  // Register read-back is purely combinational on the word address.
  always_comb begin
    rd_data = 32'd0;
    case (addr)
      ADDR_STATUS: rd_data = {23'd0, overflow, 2'b00, fifo_full, fifo_empty, status_cnt};
      ADDR_HEAD:   rd_data = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
      ADDR_CTRL:   rd_data = {31'd0, rel_en};
      ADDR_LEVELS: rd_data = {27'd0, stable};
      default:     rd_data = 32'd0;
    endcase
  end

endmodule
